// File: rtl/aoc_pkg.sv
// Shared types and ASCII helpers for the streaming puzzle solvers.
package aoc_pkg;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_FLUSH,
    ST_CONVERT,
    ST_EMIT,
    ST_DONE
  } aoc_state_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_CONV,
    CV_EMIT
  } cvt_state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  function automatic logic isDigit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/aoc_bin_to_ascii_dec.sv
// Binary -> ASCII decimal: double dabble, then a valid/ready emitter that
// sends digits MSD first with leading zeros suppressed ("0" for zero).
module aoc_bin_to_ascii_dec
  import aoc_pkg::*;
#(
  parameter int ACC_WIDTH  = 64,
  parameter int DEC_DIGITS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] value,
  output logic [7:0]           charOut,
  output logic                 charOutValid,
  input  logic                 charOutReady,
  output logic                 finished
);

  localparam int CW = $clog2(ACC_WIDTH + 1);
  localparam int IW = (DEC_DIGITS > 1) ? $clog2(DEC_DIGITS) : 1;

  cvt_state_t                  state, stateNext;
  logic [ACC_WIDTH-1:0]        binSh;
  logic [DEC_DIGITS-1:0][3:0]  bcd, bcdAdj;
  logic [CW-1:0]               bitCnt;
  logic [IW-1:0]               ptr, firstNz, curIdx;
  logic                        started, xfer;

  // Add-3 correction on every BCD digit ahead of the shift.
  always_comb begin
    bcdAdj = bcd;
    for (int i = 0; i < DEC_DIGITS; i++)
      if (bcd[i] >= 4'd5) bcdAdj[i] = bcd[i] + 4'd3;
  end

  // Highest non-zero digit; stays 0 for a zero value so "0" is emitted.
  always_comb begin
    firstNz = '0;
    for (int i = 0; i < DEC_DIGITS; i++)
      if (bcd[i] != 4'd0) firstNz = IW'(i);
  end

  // The first digit skips leading zeros without spending cycles on them.
  assign curIdx       = started ? ptr : firstNz;
  assign charOutValid = (state == CV_EMIT);
  assign charOut      = charOutValid ? (ASCII_0 + {4'd0, bcd[curIdx]}) : 8'h00;
  assign xfer         = charOutValid && charOutReady;
  assign finished     = xfer && (curIdx == '0);

  // Converter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CV_IDLE;
    else      state <= stateNext;
  end

  // Next-state: load, ACC_WIDTH shift cycles, emit until the units digit goes.
  always_comb begin
    stateNext = state;
    case (state)
      CV_IDLE: if (start) stateNext = CV_CONV;
      CV_CONV: if (bitCnt == CW'(1)) stateNext = CV_EMIT;
      CV_EMIT: if (finished) stateNext = CV_IDLE;
      default: stateNext = CV_IDLE;
    endcase
  end

  // Conversion shift register and emit pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      binSh   <= '0;
      bcd     <= '0;
      bitCnt  <= '0;
      ptr     <= '0;
      started <= 1'b0;
    end else begin
      case (state)
        CV_IDLE: if (start) begin
          binSh   <= value;
          bcd     <= '0;
          bitCnt  <= CW'(ACC_WIDTH);
          ptr     <= '0;
          started <= 1'b0;
        end
        CV_CONV: begin
          {bcd, binSh} <= {bcdAdj, binSh} << 1;
          bitCnt       <= bitCnt - CW'(1);
        end
        CV_EMIT: if (xfer) begin
          ptr     <= curIdx - IW'(1);
          started <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aoc_max_subseq_sum.sv
// Streaming "pick K digits per line, maximise, sum" solver. One DP column
// per pick depth; the line total is printed in decimal once input ends.
module aoc_max_subseq_sum
  import aoc_pkg::*;
#(
  parameter int PICK_COUNT = 12,
  parameter int ACC_WIDTH  = 64,
  parameter int DEC_DIGITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] charIn,
  input  logic       charInValid,
  output logic       charInReady,
  input  logic       stop,
  output logic [7:0] charOut,
  output logic       charOutValid,
  input  logic       charOutReady,
  output logic       done,
  output logic       overflow,
  output logic       shortLine
);

  aoc_state_t                            state, stateNext;
  logic [PICK_COUNT:1][ACC_WIDTH-1:0]    best, bestNext;
  logic [PICK_COUNT:1]                   bestVld, bestVldNext;
  logic [7:0]                            lineCnt;
  logic [ACC_WIDTH-1:0]                  sum, sumAdd, sumNext, digitVal;
  logic                                  sumCarry, accept, takeDigit, closeLine;
  logic                                  cvtFinished;

  assign accept    = charInValid && charInReady && (state == ST_ACCUM);
  assign takeDigit = accept && isDigit(charIn);
  // Empty lines (and CR-only lines) never close: nothing counted yet.
  assign closeLine = (lineCnt != 8'd0) &&
                     ((accept && (charIn == ASCII_LF)) || (state == ST_FLUSH));
  // '0'..'9' carry their value in the low nibble.
  assign digitVal  = ACC_WIDTH'(charIn[3:0]);

  // Each depth j extends depth j-1 by the new digit; all from old values.
  for (genvar j = 1; j <= PICK_COUNT; j++) begin : gDp
    logic [ACC_WIDTH-1:0] prevBest, cand;
    logic                 prevVld;
    if (j == 1) begin : gHead
      assign prevBest = '0;
      assign prevVld  = 1'b1;
    end else begin : gTail
      assign prevBest = best[j-1];
      assign prevVld  = bestVld[j-1];
    end
    assign cand           = prevBest * ACC_WIDTH'(10) + digitVal;
    assign bestNext[j]    = (cand > best[j]) ? cand : best[j];
    assign bestVldNext[j] = bestVld[j] | prevVld;
  end

  assign {sumCarry, sumAdd} = {1'b0, sum} + {1'b0, best[PICK_COUNT]};
  // The converter samples this in FLUSH so the closing line is included.
  assign sumNext = (closeLine && bestVld[PICK_COUNT]) ? sumAdd : sum;
  assign done    = (state == ST_DONE);

  // Top-level state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_ACCUM;
    else      state <= stateNext;
  end

  // Next-state: accumulate until stop, flush, then follow the converter.
  always_comb begin
    stateNext = state;
    case (state)
      ST_ACCUM:   if (stop) stateNext = ST_FLUSH;
      ST_FLUSH:   stateNext = ST_CONVERT;
      ST_CONVERT: if (cvtFinished) stateNext = ST_DONE;
                  else if (charOutValid) stateNext = ST_EMIT;
      ST_EMIT:    if (cvtFinished) stateNext = ST_DONE;
      ST_DONE:    ;
      default:    stateNext = ST_ACCUM;
    endcase
  end

  // Per-line DP table, line sum and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best        <= '0;
      bestVld     <= '0;
      lineCnt     <= '0;
      sum         <= '0;
      overflow    <= 1'b0;
      shortLine   <= 1'b0;
      charInReady <= 1'b0;
    end else begin
      charInReady <= (stateNext == ST_ACCUM);
      sum         <= sumNext;
      if (closeLine && bestVld[PICK_COUNT] && sumCarry) overflow <= 1'b1;
      if (closeLine && !bestVld[PICK_COUNT])            shortLine <= 1'b1;
      if (closeLine) begin
        best    <= '0;
        bestVld <= '0;
        lineCnt <= '0;
      end else if (takeDigit) begin
        best    <= bestNext;
        bestVld <= bestVldNext;
        if (lineCnt != 8'hFF) lineCnt <= lineCnt + 8'd1;
      end
    end
  end

  aoc_bin_to_ascii_dec #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DEC_DIGITS (DEC_DIGITS)
  ) uConv (
    .clk          (clk),
    .rst          (rst),
    .start        (state == ST_FLUSH),
    .value        (sumNext),
    .charOut      (charOut),
    .charOutValid (charOutValid),
    .charOutReady (charOutReady),
    .finished     (cvtFinished)
  );

endmodule

// File: doc/aoc_max_subseq_sum.md
# aoc_max_subseq_sum

Streaming solver for the "pick K digits per line, maximise, sum over lines" puzzle class, generalised over the pick count K and the accumulator width. It consumes the ASCII input one character per cycle and keeps a per-line dynamic-programming table. On end of input it emits the total as an ASCII decimal string through a valid/ready output. One instance per puzzle part (K=2 and K=12 for the 2025 day 3 puzzle) sits behind the shared character feeder.

## Interface
- PICK_COUNT, 12: digits chosen per line (K); 1 ≤ K ≤ 19.
- ACC_WIDTH, 64: width of DP entries and of the line sum; must hold 10^K−1.
- DEC_DIGITS, 20: BCD digits of the output conversion; must satisfy 10^DEC_DIGITS > 2^ACC_WIDTH.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- charIn  in  8  input ASCII character.
- charInValid  in  1  charIn is valid this cycle.
- charInReady  out  1  block accepts charIn.
- stop  in  1  end of input; level, held until reset.
- charOut  out  8  ASCII result digit.
- charOutValid  out  1  charOut is valid.
- charOutReady  in  1  consumer takes charOut.
- done  out  1  last result character has been transferred.
- overflow  out  1  sticky: the sum wrapped modulo 2^ACC_WIDTH.
- shortLine  out  1  sticky: a non-empty line had fewer than K digits.

## Operation
- States: ACCUM → FLUSH → CONVERT → EMIT → DONE.
- ACCUM: charInReady=1. A character is accepted when charInValid=1 && charInReady=1.
  - Digit '0'..'9' (value d): for j = K down to 1, in parallel from old values, best[j] ← max(best[j], best[j−1]·10+d). best[0] ≡ 0. valid[j] ← valid[j] | valid[j−1]; valid[0] ≡ 1. The line digit count increments.
  - '\n': if the line count is 0, the character is ignored. Otherwise, if valid[K] then sum ← sum+best[K]; if not valid[K], shortLine←1. Then clear best, valid, and the count.
  - '\r' and every other character are ignored.
- stop=1 in ACCUM: go to FLUSH. If a character is accepted in the same cycle, it is processed first.
- FLUSH: one cycle. A pending unterminated line is closed exactly as for '\n'. charInReady=0 from FLUSH onward.
- CONVERT: double dabble, ACC_WIDTH cycles, sum → DEC_DIGITS BCD digits.
- EMIT: output digits MSD first, with leading zeros suppressed. A zero sum emits the single character "0". charOut = 8'h30 + digit.
- DONE: done=1 and stays high until reset. All inputs are ignored.
- The sum carry-out sets overflow; the sum wraps.

## Timing
- Reset values: charInReady=0 during reset and 1 from the first edge after release; charOut=0, charOutValid=0, done=0, overflow=0, shortLine=0; state ACCUM; best, valid, sum, and count are all 0.
- Throughput is 1 character/cycle in ACCUM. An accepted digit is visible in best on the next cycle. A '\n' is reflected in sum on the next cycle.
- Latency from the first stop cycle to the first charOutValid: 1 (FLUSH) + ACC_WIDTH (CONVERT) + 1 cycles.
- Output handshake: charOut and charOutValid are held stable while charOutReady=0. A transfer happens on an edge where valid && ready. The next digit is presented on the following cycle, or valid drops on the last digit.
- done rises on the cycle after the last transfer.
- Asserting rst at any point, including mid-CONVERT or mid-EMIT, aborts immediately and restores the reset values. No partial string resumes.
- stop dropping after it has been seen has no effect.

## Structure
- Package aoc_pkg holds:
  - the state enum;
  - ASCII constants: ASCII_0=8'h30, ASCII_9, ASCII_LF=8'h0A, ASCII_CR=8'h0D;
  - a function isDigit(char).
- Sub-module aoc_bin_to_ascii_dec, parameters ACC_WIDTH and DEC_DIGITS:
  - a start pulse plus the binary value goes in;
  - it performs the double dabble conversion, zero suppression, and the valid/ready ASCII emitter;
  - it produces a finished pulse.
  - The same module is to be reused by other days.

## Test plan
- Lines 987654321111111, 811111111111119, 234234234234278, 818181911112111 (each '\n'-terminated), then stop:
  - K=2 → "357";
  - K=12 → "3121910778619";
  - overflow=0 and shortLine=0 for both.
- K=2, input "12" with no trailing '\n', then stop → "12". Add "\r\n\n" between lines → same result; empty lines are ignored.
- K=2, "9\n" then stop → "0", shortLine=1. No input then stop → "0", shortLine=0.
- K=2, ACC_WIDTH=8, DEC_DIGITS=3, "99\n99\n99\n" → sum 297 mod 256 = "41", overflow=1.
- charOutReady toggled randomly and held low for 10 cycles mid-string → the identical string is received, with no drops or duplicates, and charOut is stable while stalled.
- rst pulsed low during EMIT, then the first test set is replayed → the clean "357" result, all flags 0, and done only at the end.
